// File: rtl/map_tile_store_pkg.sv
// Shared tile codes, map geometry and helpers for the Pacman tile store.
package map_tile_store_pkg;

    localparam int MAP_W     = 21;
    localparam int MAP_H     = 21;
    localparam int MAP_N     = MAP_W * MAP_H;
    localparam int CNT_W     = 9;
    localparam int ORB_TOTAL = 280;

    localparam logic [2:0] TILE_BLACK     = 3'b000;
    localparam logic [2:0] TILE_BIG_ORB   = 3'b001;
    localparam logic [2:0] TILE_SMALL_ORB = 3'b010;
    localparam logic [2:0] TILE_BLUE      = 3'b011;
    localparam logic [2:0] TILE_GREY      = 3'b100;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    function automatic logic is_orb(input logic [2:0] t);
        return (t == TILE_BIG_ORB) || (t == TILE_SMALL_ORB);
    endfunction

    function automatic logic in_map(input logic [4:0] x, input logic [4:0] y);
        return (x <= 5'(MAP_W - 1)) && (y <= 5'(MAP_H - 1));
    endfunction

    function automatic logic [8:0] tile_idx(input logic [4:0] x, input logic [4:0] y);
        return 9'(y) * 9'(MAP_W) + 9'(x);
    endfunction

    // Unused codes 101-111 read back as grey wall.
    function automatic logic [2:0] norm_tile(input logic [2:0] t);
        return (t > TILE_GREY) ? TILE_GREY : t;
    endfunction

endpackage

// File: rtl/map_tile_store_if.sv
// Display query, game query, eat command and status signals of the tile store.
interface map_tile_store_if;
    import map_tile_store_pkg::*;

    logic [4:0]       map_x;
    logic [4:0]       map_y;
    logic [2:0]       sprite_type;
    logic [4:0]       query_x;
    logic [4:0]       query_y;
    logic [2:0]       query_type;
    logic             eat_en;
    logic [4:0]       eat_x;
    logic [4:0]       eat_y;
    logic             eat_valid;
    logic             eat_big;
    logic [CNT_W-1:0] orbs_remaining;
    logic             level_clear;
    logic             init_done;

    modport master (
        output map_x, map_y, query_x, query_y, eat_en, eat_x, eat_y,
        input  sprite_type, query_type, eat_valid, eat_big, orbs_remaining, level_clear, init_done
    );

    modport slave (
        input  map_x, map_y, query_x, query_y, eat_en, eat_x, eat_y,
        output sprite_type, query_type, eat_valid, eat_big, orbs_remaining, level_clear, init_done
    );

endinterface

// File: rtl/map_layout_rom.sv
// Level layout: blue border ring, big orbs in the four inner corners, grey
// pillars on even/even cells, an empty centre, small orbs everywhere else.
module map_layout_rom
    import map_tile_store_pkg::*;
(
    input  logic [8:0] idx,
    output logic [2:0] tile
);

    logic [8:0] col;
    logic [8:0] row;

    always_comb begin
        col  = idx % 9'(MAP_W);
        row  = idx / 9'(MAP_W);
        tile = TILE_SMALL_ORB;
        if (idx > 9'(MAP_N - 1))
            tile = TILE_BLACK;
        else if (col == 9'd0 || col == 9'd20 || row == 9'd0 || row == 9'd20)
            tile = TILE_BLUE;
        else if ((col == 9'd1 || col == 9'd19) && (row == 9'd1 || row == 9'd19))
            tile = TILE_BIG_ORB;
        else if (col == 9'd10 && row == 9'd10)
            tile = TILE_BLACK;
        else if (!col[0] && !row[0])
            tile = TILE_GREY;
    end

endmodule

// File: rtl/map_tile_store.sv
// Live 21x21 tile map: loads the layout after reset, serves two async read
// ports and removes orbs on eat commands while tracking the orb count.
//
// state   | meaning
// ST_INIT | copying layout ROM into storage, one tile per cycle; ports dark
// ST_RUN  | map live, reads served, eat commands accepted
module map_tile_store
    import map_tile_store_pkg::*;
(
    input  logic            clock_50,
    input  logic            reset,
    map_tile_store_if.slave bus
);

    logic [2:0]       tiles [MAP_N];
    state_t           state_q, state_d;
    logic [8:0]       init_idx_q, init_idx_d;
    logic [CNT_W-1:0] orbs_q, orbs_d;
    logic             eat_valid_q, eat_valid_d;
    logic             eat_big_q, eat_big_d;
    logic             wr_en;
    logic [8:0]       wr_idx;
    logic [2:0]       wr_data;
    logic [2:0]       rom_tile;
    logic [8:0]       disp_idx, query_idx, eat_idx;
    logic [2:0]       eat_tile;
    logic             eat_hit;

    map_layout_rom u_rom (
        .idx  (init_idx_q),
        .tile (rom_tile)
    );

    assign disp_idx  = tile_idx(bus.map_x, bus.map_y);
    assign query_idx = tile_idx(bus.query_x, bus.query_y);
    assign eat_idx   = tile_idx(bus.eat_x, bus.eat_y);
    assign eat_tile  = in_map(bus.eat_x, bus.eat_y) ? tiles[eat_idx] : TILE_BLACK;
    assign eat_hit   = (state_q == ST_RUN) && bus.eat_en && is_orb(eat_tile);

    assign bus.sprite_type = (state_q == ST_RUN && in_map(bus.map_x, bus.map_y))
                             ? norm_tile(tiles[disp_idx]) : TILE_BLACK;
    assign bus.query_type  = (state_q == ST_RUN && in_map(bus.query_x, bus.query_y))
                             ? norm_tile(tiles[query_idx]) : TILE_BLACK;

    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        orbs_d      = orbs_q;
        eat_valid_d = 1'b0;
        eat_big_d   = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = init_idx_q;
        wr_data     = rom_tile;
        case (state_q)
            ST_INIT: begin
                wr_en = 1'b1;
                if (is_orb(rom_tile))
                    orbs_d = orbs_q + 1'b1;
                if (init_idx_q == 9'(MAP_N - 1))
                    state_d = ST_RUN;
                else
                    init_idx_d = init_idx_q + 9'd1;
            end
            ST_RUN: begin
                if (eat_hit) begin
                    wr_en       = 1'b1;
                    wr_idx      = eat_idx;
                    wr_data     = TILE_BLACK;
                    orbs_d      = orbs_q - 1'b1;
                    eat_valid_d = 1'b1;
                    eat_big_d   = (eat_tile == TILE_BIG_ORB);
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            state_q     <= ST_INIT;
            init_idx_q  <= '0;
            orbs_q      <= '0;
            eat_valid_q <= 1'b0;
            eat_big_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            orbs_q      <= orbs_d;
            eat_valid_q <= eat_valid_d;
            eat_big_q   <= eat_big_d;
        end
    end

    // Storage has no reset; INIT overwrites every entry before it is read.
    always_ff @(posedge clock_50) begin
        if (wr_en && !reset)
            tiles[wr_idx] <= wr_data;
    end

    assign bus.eat_valid      = eat_valid_q;
    assign bus.eat_big        = eat_big_q;
    assign bus.orbs_remaining = orbs_q;
    assign bus.init_done      = (state_q == ST_RUN);
    assign bus.level_clear    = (state_q == ST_RUN) && (orbs_q == '0);

endmodule

// File: tb/tb_map_tile_store.sv
// Self-checking bench for map_tile_store: load timing, eats, reads, level clear and restart.
module tb_map_tile_store;
    import map_tile_store_pkg::*;

    typedef struct packed {
        logic v;
        logic b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_orbs = 0;
    exp_t sb[$];
    exp_t e;

    map_tile_store_if bus();

    map_tile_store dut (
        .clock_50 (clk),
        .reset    (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit early = 0;
        bit pulsed = 0;
        repeat (3) step();
        bus.map_x = 5'd0; bus.map_y = 5'd0;
        #1;
        n_cmp++; if (bus.init_done !== 1'b0) begin n_bad++; $display("FAIL reset_init_done: got %0b want 0", bus.init_done); end
        n_cmp++; if (bus.orbs_remaining !== '0) begin n_bad++; $display("FAIL reset_orbs: got %0d want 0", bus.orbs_remaining); end
        n_cmp++; if ({bus.eat_valid, bus.eat_big} !== 2'b00) begin n_bad++; $display("FAIL reset_pulses: got %b want 00", {bus.eat_valid, bus.eat_big}); end
        n_cmp++; if (bus.sprite_type !== TILE_BLACK) begin n_bad++; $display("FAIL init_read_dark: got %0d want 0", bus.sprite_type); end
        rst = 1'b0;
        bus.eat_en = 1'b1; bus.eat_x = 5'd1; bus.eat_y = 5'd1;
        for (int i = 1; i <= 440; i++) begin
            step();
            if (bus.init_done) early = 1;
            if (bus.eat_valid || bus.eat_big) pulsed = 1;
        end
        n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL init_done_early: got %0b want 0", early); end
        step();
        if (bus.eat_valid || bus.eat_big) pulsed = 1;
        bus.eat_en = 1'b0;
        exp_orbs = ORB_TOTAL;
        n_cmp++; if (pulsed !== 1'b0) begin n_bad++; $display("FAIL init_eat_ignored: got %0b want 0", pulsed); end
        n_cmp++; if (bus.init_done !== 1'b1) begin n_bad++; $display("FAIL init_done_441: got %0b want 1", bus.init_done); end
        n_cmp++; if (bus.orbs_remaining !== CNT_W'(exp_orbs)) begin n_bad++; $display("FAIL init_orbs: got %0d want %0d", bus.orbs_remaining, exp_orbs); end
        n_cmp++; if (bus.sprite_type !== TILE_BLUE) begin n_bad++; $display("FAIL tile_0_0: got %0d want 3", bus.sprite_type); end
        bus.map_x = 5'd1; bus.map_y = 5'd1; bus.query_x = 5'd2; bus.query_y = 5'd1;
        #1;
        n_cmp++; if (bus.sprite_type !== TILE_BIG_ORB) begin n_bad++; $display("FAIL tile_1_1: got %0d want 1", bus.sprite_type); end
        n_cmp++; if (bus.query_type !== TILE_SMALL_ORB) begin n_bad++; $display("FAIL tile_2_1: got %0d want 2", bus.query_type); end
        n_cmp++; if (bus.level_clear !== 1'b0) begin n_bad++; $display("FAIL clear_after_init: got %0b want 0", bus.level_clear); end
    endtask

    task automatic test_eat_big();
        bus.eat_en = 1'b1; bus.eat_x = 5'd1; bus.eat_y = 5'd1;
        sb.push_back('{v: 1'b1, b: 1'b1});
        exp_orbs--;
        step();
        bus.eat_en = 1'b0;
        e = sb.pop_front();
        n_cmp++; if ({bus.eat_valid, bus.eat_big} !== {e.v, e.b}) begin n_bad++; $display("FAIL eat_big_pulse: got %b want %b", {bus.eat_valid, bus.eat_big}, {e.v, e.b}); end
        n_cmp++; if (bus.orbs_remaining !== CNT_W'(exp_orbs)) begin n_bad++; $display("FAIL eat_big_count: got %0d want %0d", bus.orbs_remaining, exp_orbs); end
        bus.map_x = 5'd1; bus.map_y = 5'd1;
        #1;
        n_cmp++; if (bus.sprite_type !== TILE_BLACK) begin n_bad++; $display("FAIL eat_big_cleared: got %0d want 0", bus.sprite_type); end
        step();
        n_cmp++; if ({bus.eat_valid, bus.eat_big} !== 2'b00) begin n_bad++; $display("FAIL eat_big_one_cycle: got %b want 00", {bus.eat_valid, bus.eat_big}); end
    endtask

    task automatic test_back_to_back();
        bus.eat_en = 1'b1; bus.eat_x = 5'd2; bus.eat_y = 5'd1;
        sb.push_back('{v: 1'b1, b: 1'b0});
        exp_orbs--;
        step();
        e = sb.pop_front();
        n_cmp++; if ({bus.eat_valid, bus.eat_big} !== {e.v, e.b}) begin n_bad++; $display("FAIL b2b_first: got %b want %b", {bus.eat_valid, bus.eat_big}, {e.v, e.b}); end
        sb.push_back('{v: 1'b0, b: 1'b0});
        step();
        bus.eat_en = 1'b0;
        e = sb.pop_front();
        n_cmp++; if ({bus.eat_valid, bus.eat_big} !== {e.v, e.b}) begin n_bad++; $display("FAIL b2b_second: got %b want %b", {bus.eat_valid, bus.eat_big}, {e.v, e.b}); end
        n_cmp++; if (bus.orbs_remaining !== CNT_W'(exp_orbs)) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", bus.orbs_remaining, exp_orbs); end
    endtask

    task automatic test_non_orb();
        bus.eat_en = 1'b1; bus.eat_x = 5'd0; bus.eat_y = 5'd5;
        sb.push_back('{v: 1'b0, b: 1'b0});
        step();
        e = sb.pop_front();
        n_cmp++; if ({bus.eat_valid, bus.eat_big} !== {e.v, e.b}) begin n_bad++; $display("FAIL eat_wall: got %b want %b", {bus.eat_valid, bus.eat_big}, {e.v, e.b}); end
        bus.eat_x = 5'd21; bus.eat_y = 5'd3;
        sb.push_back('{v: 1'b0, b: 1'b0});
        step();
        bus.eat_en = 1'b0;
        e = sb.pop_front();
        n_cmp++; if ({bus.eat_valid, bus.eat_big} !== {e.v, e.b}) begin n_bad++; $display("FAIL eat_out_of_range: got %b want %b", {bus.eat_valid, bus.eat_big}, {e.v, e.b}); end
        n_cmp++; if (bus.orbs_remaining !== CNT_W'(exp_orbs)) begin n_bad++; $display("FAIL non_orb_count: got %0d want %0d", bus.orbs_remaining, exp_orbs); end
        bus.query_x = 5'd21; bus.query_y = 5'd3;
        #1;
        n_cmp++; if (bus.query_type !== TILE_BLACK) begin n_bad++; $display("FAIL query_21_3: got %0d want 0", bus.query_type); end
        bus.query_x = 5'd0; bus.query_y = 5'd5;
        #1;
        n_cmp++; if (bus.query_type !== TILE_BLUE) begin n_bad++; $display("FAIL query_0_5: got %0d want 3", bus.query_type); end
    endtask

    task automatic test_read_during_eat();
        bus.map_x = 5'd3; bus.map_y = 5'd4;
        bus.eat_en = 1'b1; bus.eat_x = 5'd3; bus.eat_y = 5'd4;
        sb.push_back('{v: 1'b1, b: 1'b0});
        exp_orbs--;
        #1;
        n_cmp++; if (bus.sprite_type !== TILE_SMALL_ORB) begin n_bad++; $display("FAIL read_pre_eat: got %0d want 2", bus.sprite_type); end
        step();
        bus.eat_en = 1'b0;
        e = sb.pop_front();
        n_cmp++; if ({bus.eat_valid, bus.eat_big} !== {e.v, e.b}) begin n_bad++; $display("FAIL read_eat_pulse: got %b want %b", {bus.eat_valid, bus.eat_big}, {e.v, e.b}); end
        n_cmp++; if (bus.sprite_type !== TILE_BLACK) begin n_bad++; $display("FAIL read_post_eat: got %0d want 0", bus.sprite_type); end
    endtask

    task automatic test_eat_all();
        int  pulses = 0;
        bit  early_clear = 0;
        for (int y = 0; y < MAP_H; y++) begin
            for (int x = 0; x < MAP_W; x++) begin
                bus.eat_en = 1'b1; bus.eat_x = 5'(x); bus.eat_y = 5'(y);
                step();
                if (bus.eat_valid) pulses++;
                if (bus.level_clear && pulses < exp_orbs) early_clear = 1;
            end
        end
        bus.eat_en = 1'b0;
        n_cmp++; if (pulses !== exp_orbs) begin n_bad++; $display("FAIL sweep_pulses: got %0d want %0d", pulses, exp_orbs); end
        n_cmp++; if (early_clear !== 1'b0) begin n_bad++; $display("FAIL sweep_early_clear: got %0b want 0", early_clear); end
        n_cmp++; if (bus.orbs_remaining !== '0) begin n_bad++; $display("FAIL sweep_count: got %0d want 0", bus.orbs_remaining); end
        n_cmp++; if (bus.level_clear !== 1'b1) begin n_bad++; $display("FAIL level_clear: got %0b want 1", bus.level_clear); end
        exp_orbs = 0;
    endtask

    task automatic test_restart();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (bus.level_clear !== 1'b0) begin n_bad++; $display("FAIL restart_clear: got %0b want 0", bus.level_clear); end
        n_cmp++; if (bus.init_done !== 1'b0) begin n_bad++; $display("FAIL restart_init_done: got %0b want 0", bus.init_done); end
        repeat (441) step();
        exp_orbs = ORB_TOTAL;
        n_cmp++; if (bus.init_done !== 1'b1) begin n_bad++; $display("FAIL restart_done: got %0b want 1", bus.init_done); end
        n_cmp++; if (bus.orbs_remaining !== CNT_W'(exp_orbs)) begin n_bad++; $display("FAIL restart_orbs: got %0d want %0d", bus.orbs_remaining, exp_orbs); end
        bus.map_x = 5'd1; bus.map_y = 5'd1; bus.query_x = 5'd19; bus.query_y = 5'd19;
        #1;
        n_cmp++; if (bus.sprite_type !== TILE_BIG_ORB) begin n_bad++; $display("FAIL restart_1_1: got %0d want 1", bus.sprite_type); end
        n_cmp++; if (bus.query_type !== TILE_BIG_ORB) begin n_bad++; $display("FAIL restart_19_19: got %0d want 1", bus.query_type); end
        bus.map_x = 5'd19; bus.map_y = 5'd1; bus.query_x = 5'd1; bus.query_y = 5'd19;
        #1;
        n_cmp++; if (bus.sprite_type !== TILE_BIG_ORB) begin n_bad++; $display("FAIL restart_19_1: got %0d want 1", bus.sprite_type); end
        n_cmp++; if (bus.query_type !== TILE_BIG_ORB) begin n_bad++; $display("FAIL restart_1_19: got %0d want 1", bus.query_type); end
        bus.map_x = 5'd20; bus.map_y = 5'd7;
        #1;
        n_cmp++; if (bus.sprite_type !== TILE_BLUE) begin n_bad++; $display("FAIL restart_20_7: got %0d want 3", bus.sprite_type); end
    endtask

    initial begin
        bus.map_x = 5'd0; bus.map_y = 5'd0;
        bus.query_x = 5'd0; bus.query_y = 5'd0;
        bus.eat_en = 1'b0; bus.eat_x = 5'd0; bus.eat_y = 5'd0;
        @(negedge clk);
        test_reset();
        test_eat_big();
        test_back_to_back();
        test_non_orb();
        test_read_during_eat();
        test_eat_all();
        test_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
